rib_master_arbiter: RTL and testbench
=====================================

// Module: rib_master_arbiter
// PURPOSE
//  Registered arbiter that shares the RIB slave fabric among the four bus masters:
//  m0 core ex, m1 pc fetch, m2 jtag and m3 uart_debug.
//  It replaces ad-hoc combinational priority with an explicit grant state machine.
//  It locks the grant across multi-cycle slaves (i2c ready handshake) and bounds the lock with a timeout.
//  It sits beside the rib crossbar; rib uses grant_o to steer the master mux, and hold_flag_o stalls the core.
// PARAMETERS
//  NUM_MASTER    4     number of requesters (index = master number)
//  DEFAULT_M     1     master parked on the bus when idle (pc fetch)
//  TIMEOUT_CYC   255   max cycles a grant may wait for ready_i before abort; 8-bit counter
// PORTS
//  clk           in   1           system clock
//  rst           in   1           synchronous reset, active-high
//  req_i         in   NUM_MASTER  per-master request; bit DEFAULT_M is tied high by the SoC
//  ready_i       in   1           addressed slave completed the current beat
//  grant_o       out  NUM_MASTER  one-hot grant, registered
//  grant_idx_o   out  2           binary index of grant_o
//  hold_flag_o   out  1           core pipeline hold; high while a non-default master owns the bus
//  timeout_o     out  1           one-cycle pulse on grant abort
// BEHAVIOUR
//  Reset values: grant_o=1<<DEFAULT_M, grant_idx_o=DEFAULT_M, hold_flag_o=0, timeout_o=0, wait counter=0, state=IDLE.
//  Fixed priority, highest first: m3 > m0 > m2 > m1. The pick is computed from req_i of the non-default masters.
//  Latency: a request seen at edge N is granted at edge N+1. Grant is never combinational from req_i.
//  IDLE:  grant=DEFAULT_M, hold=0.
//    If any non-default req is high: latch the winner, go to BUSY.
//  BUSY:  grant=winner, hold=1.
//    ready_i=1: beat done and counter cleared.
//      Re-arbitrate: if a non-default req is high, grant the new winner (possibly the same one) and stay in BUSY.
//      Otherwise go to IDLE.
//    ready_i=0 and winner req=1: hold the grant (lock) and increment the counter.
//    ready_i=0 and winner req=0: abandoned beat; re-arbitrate as if ready_i=1, with no timeout pulse.
//    Counter reaches TIMEOUT_CYC: go to ABORT.
//  ABORT: one cycle; grant_o=0, grant_idx_o holds the last value, hold=1, timeout_o=1, counter cleared; next state IDLE.
//  Simultaneous events:
//    A higher-priority request arriving during a lock never pre-empts the lock; it waits for the beat to end.
//    If ready_i and the timeout compare occur in the same cycle, ready_i wins (no abort).
//  rst asserted mid-beat: all registers return to reset values at that edge. No partial grant survives.
//  The counter saturates at TIMEOUT_CYC and never wraps.
//  grant_o is always one-hot, except all-zero in ABORT. An assertion checks $onehot0.
// CONFIGURATION
//  `RIB_ARB_RR_EN defined: round-robin among the non-default masters.
//    Search starts at the master after the last BUSY winner; the pointer updates only on a completed beat.
//    The pointer resets to m3.
//  Undefined: fixed priority m3 > m0 > m2 as above.
//  Port list, state machine, timing and reset values are identical in both builds.
// STRUCTURE
//  Package rib_arb_pkg holds:
//    state encoding IDLE/BUSY/ABORT (2-bit localparams)
//    master index constants M_CORE=0, M_PC=1, M_JTAG=2, M_UART=3
//    TIMEOUT counter width
//  Sub-module rib_arb_pick is combinational: it takes req mask and rr pointer and returns the winner index plus a valid flag.
//  The priority-versus-round-robin choice lives only inside rib_arb_pick under the macro.
//  The top level owns the state machine, counter, registered outputs and the rr pointer register.
// TESTING
//  1 Reset with req_i=4'b0010 -> grant_o=4'b0010, grant_idx_o=1, hold=0 on the first edge after rst drops.
//  2 req_i=4'b1111 for 1 cycle, ready_i=1 -> next edge grant_o=4'b1000, hold=1.
//    Then req m3 drops -> grant m0 (4'b0001), then m2, then IDLE.
//  3 Grant m2, ready_i=0 for 10 cycles, m3 requests at cycle 3 -> grant stays 4'b0100 until ready_i=1.
//    m3 is granted the following edge.
//  4 Grant m0, ready_i held 0 -> at 255 wait cycles ABORT.
//    timeout_o=1 for exactly one cycle, grant_o=0, then IDLE with grant_o=4'b0010.
//  5 rst pulsed during a BUSY lock -> next edge outputs equal the reset values and the counter reads 0.
//  6 With `RIB_ARB_RR_EN, req_i=4'b1111 held and ready_i=1 -> grant sequence m3, m0, m2, m3, ...
//    Without the macro, the same stimulus -> m3 every beat.

Source files
------------

// File: rtl/rib_arb_pkg.sv
// rtl/rib_arb_pkg.sv - shared constants for the RIB master arbiter
//
// Purpose: grant state encoding, master index constants and wait-counter width
//          used by rib_master_arbiter and rib_arb_pick.
// Ports:   none (package)
package rib_arb_pkg;

  // Grant state machine encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_ABORT = 2'd2;

  // Master numbering on the RIB fabric
  localparam logic [1:0] M_CORE = 2'd0;  // core ex stage
  localparam logic [1:0] M_PC   = 2'd1;  // pc fetch, parked master
  localparam logic [1:0] M_JTAG = 2'd2;
  localparam logic [1:0] M_UART = 2'd3;  // uart debug

  // Width of the grant wait counter
  localparam int CNT_W = 8;

endpackage

// File: rtl/rib_arb_pick.sv
// rtl/rib_arb_pick.sv - combinational winner selection for the RIB arbiter
//
// Purpose: picks one winner among the non-default masters.
//          Build option: RIB_ARB_RR_EN selects round-robin starting at rr_ptr_i;
//          otherwise fixed priority m3 > m0 > m2.
// Ports:
//   req_i        in  NUM_MASTER  raw request vector (default master bit is ignored)
//   rr_ptr_i     in  2           first master examined in round-robin mode
//   win_idx_o    out 2           index of the winner
//   win_valid_o  out 1           at least one non-default master is requesting
module rib_arb_pick
  import rib_arb_pkg::*;
#(
  parameter int NUM_MASTER = 4,
  parameter int DEFAULT_M  = 1
) (
  input  logic [NUM_MASTER-1:0] req_i,
  input  logic [1:0]            rr_ptr_i,
  output logic [1:0]            win_idx_o,
  output logic                  win_valid_o
);

  // The parked master is always requesting, so it never competes here.
  logic [NUM_MASTER-1:0] cand;
  assign cand = req_i & ~(NUM_MASTER'(1) << DEFAULT_M);

`ifdef RIB_ARB_RR_EN
  logic [1:0] idx;

  // Scan from the farthest offset down to offset 0 so the candidate
  // closest to the pointer is the last (and therefore winning) assignment.
  always_comb begin
    win_idx_o   = rr_ptr_i;
    win_valid_o = 1'b0;
    idx         = rr_ptr_i;
    for (int off = NUM_MASTER - 1; off >= 0; off--) begin
      idx = rr_ptr_i + off[1:0];
      if (cand[idx]) begin
        win_idx_o   = idx;
        win_valid_o = 1'b1;
      end
    end
  end
`else
  // Pointer only matters for round-robin; fold it away in this build.
  logic unused_ptr;
  assign unused_ptr = ^rr_ptr_i;

  always_comb begin
    win_valid_o = |cand;
    if (cand[M_UART])      win_idx_o = M_UART;
    else if (cand[M_CORE]) win_idx_o = M_CORE;
    else if (cand[M_JTAG]) win_idx_o = M_JTAG;
    else                   win_idx_o = 2'(DEFAULT_M);
  end
`endif

endmodule

// File: rtl/rib_master_arbiter.sv
// rtl/rib_master_arbiter.sv - registered grant arbiter for the four RIB masters
//
// Purpose: shares the RIB slave fabric among m0 core ex, m1 pc fetch, m2 jtag
//          and m3 uart debug. A grant is locked until the slave signals ready_i
//          and aborted after TIMEOUT_CYC wait cycles.
//          Build option: RIB_ARB_RR_EN enables round-robin among non-default masters.
// Ports:
//   clk          in  1           system clock
//   rst          in  1           synchronous reset, active-high
//   req_i        in  NUM_MASTER  per-master request
//   ready_i      in  1           addressed slave completed the current beat
//   grant_o      out NUM_MASTER  one-hot grant (all-zero during abort)
//   grant_idx_o  out 2           binary index of grant_o
//   hold_flag_o  out 1           core pipeline hold while a non-default master owns the bus
//   timeout_o    out 1           one-cycle pulse on grant abort
module rib_master_arbiter
  import rib_arb_pkg::*;
#(
  parameter int NUM_MASTER  = 4,
  parameter int DEFAULT_M   = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_MASTER-1:0] req_i,
  input  logic                  ready_i,
  output logic [NUM_MASTER-1:0] grant_o,
  output logic [1:0]            grant_idx_o,
  output logic                  hold_flag_o,
  output logic                  timeout_o
);

  localparam logic [CNT_W-1:0]      TMO      = CNT_W'(TIMEOUT_CYC);
  localparam logic [1:0]            DEF_IDX  = 2'(DEFAULT_M);
  localparam logic [NUM_MASTER-1:0] DEF_OH   = NUM_MASTER'(1) << DEFAULT_M;

  logic [1:0]            state_q, state_d;
  logic [1:0]            win_q, win_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [NUM_MASTER-1:0] grant_q, grant_d;
  logic [1:0]            idx_q, idx_d;
  logic                  hold_q, hold_d;
  logic                  tout_q, tout_d;

  logic [1:0] pick_ptr;
  logic [1:0] pick_idx;
  logic       pick_valid;

  // A completed beat searches from the master after the one just served;
  // otherwise the search resumes from the stored pointer.
  assign pick_ptr = (state_q == S_BUSY && ready_i) ? win_q + 2'd1 : ptr_q;

  rib_arb_pick #(
    .NUM_MASTER (NUM_MASTER),
    .DEFAULT_M  (DEFAULT_M)
  ) u_pick (
    .req_i       (req_i),
    .rr_ptr_i    (pick_ptr),
    .win_idx_o   (pick_idx),
    .win_valid_o (pick_valid)
  );

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (pick_valid) begin
          state_d = S_BUSY;
          win_d   = pick_idx;
        end
      end
      S_BUSY: begin
        // Beat done, or winner walked away: re-arbitrate without a timeout.
        // ready_i is checked before the timeout compare so it wins a tie.
        if (ready_i || !req_i[win_q]) begin
          cnt_d = '0;
          if (ready_i) ptr_d = pick_ptr;
          if (pick_valid) begin
            win_d = pick_idx;
          end else begin
            state_d = S_IDLE;
          end
        end else if (cnt_q == TMO) begin
          state_d = S_ABORT;
          cnt_d   = '0;
        end else begin
          // Increment only below TMO, so the counter saturates rather than wraps.
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ABORT: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they appear as registers.
  always_comb begin
    grant_d = DEF_OH;
    idx_d   = DEF_IDX;
    hold_d  = 1'b0;
    tout_d  = 1'b0;
    case (state_d)
      S_BUSY: begin
        grant_d = NUM_MASTER'(1) << win_d;
        idx_d   = win_d;
        hold_d  = 1'b1;
      end
      S_ABORT: begin
        grant_d = '0;
        idx_d   = idx_q;
        hold_d  = 1'b1;
        tout_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      win_q   <= DEF_IDX;
      cnt_q   <= '0;
      ptr_q   <= M_UART;
      grant_q <= DEF_OH;
      idx_q   <= DEF_IDX;
      hold_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      tout_q  <= tout_d;
    end
  end

  assign grant_o     = grant_q;
  assign grant_idx_o = idx_q;
  assign hold_flag_o = hold_q;
  assign timeout_o   = tout_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));

endmodule

// File: tb/tb_rib_master_arbiter.sv
// tb/tb_rib_master_arbiter.sv - directed self-checking bench for rib_master_arbiter
module tb_rib_master_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i;
  logic       ready_i;
  logic [3:0] grant_o;
  logic [1:0] grant_idx_o;
  logic       hold_flag_o;
  logic       timeout_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rib_master_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .ready_i     (ready_i),
    .grant_o     (grant_o),
    .grant_idx_o (grant_idx_o),
    .hold_flag_o (hold_flag_o),
    .timeout_o   (timeout_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_i = 4'b0010; ready_i = 1'b0;
    step(); step();
    total++; if (grant_o !== 4'b0010) begin bad++; $display("FAIL rst_in_grant got=%b want=0010", grant_o); end
    rst = 1'b0;
    step();
    total++; if (grant_o !== 4'b0010) begin bad++; $display("FAIL reset_grant got=%b want=0010", grant_o); end
    total++; if (grant_idx_o !== 2'd1) begin bad++; $display("FAIL reset_idx got=%0d want=1", grant_idx_o); end
    total++; if (hold_flag_o !== 1'b0) begin bad++; $display("FAIL reset_hold got=%b want=0", hold_flag_o); end
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout_o); end
  endtask

  task automatic test_priority();
    req_i = 4'b1111; ready_i = 1'b1;
    step();
    total++; if (grant_o !== 4'b1000) begin bad++; $display("FAIL prio_m3 got=%b want=1000", grant_o); end
    total++; if (hold_flag_o !== 1'b1) begin bad++; $display("FAIL prio_hold got=%b want=1", hold_flag_o); end
    total++; if (grant_idx_o !== 2'd3) begin bad++; $display("FAIL prio_idx3 got=%0d want=3", grant_idx_o); end
    req_i = 4'b0111;
    step();
    total++; if (grant_o !== 4'b0001) begin bad++; $display("FAIL prio_m0 got=%b want=0001", grant_o); end
    req_i = 4'b0110;
    step();
    total++; if (grant_o !== 4'b0100) begin bad++; $display("FAIL prio_m2 got=%b want=0100", grant_o); end
    req_i = 4'b0010;
    step();
    total++; if (grant_o !== 4'b0010) begin bad++; $display("FAIL prio_idle got=%b want=0010", grant_o); end
    total++; if (hold_flag_o !== 1'b0) begin bad++; $display("FAIL prio_idle_hold got=%b want=0", hold_flag_o); end
  endtask

  task automatic test_lock();
    int broke = 0;
    req_i = 4'b0110; ready_i = 1'b0;
    step();
    total++; if (grant_o !== 4'b0100) begin bad++; $display("FAIL lock_start got=%b want=0100", grant_o); end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) req_i = 4'b1110;
      step();
      if (grant_o !== 4'b0100) broke++;
    end
    total++; if (broke !== 0) begin bad++; $display("FAIL lock_held got=%0d broken cycles want=0", broke); end
    total++; if (dut.cnt_q !== 8'd10) begin bad++; $display("FAIL lock_cnt got=%0d want=10", dut.cnt_q); end
    ready_i = 1'b1;
    step();
    total++; if (grant_o !== 4'b1000) begin bad++; $display("FAIL lock_then_m3 got=%b want=1000", grant_o); end
    total++; if (dut.cnt_q !== 8'd0) begin bad++; $display("FAIL lock_cnt_clr got=%0d want=0", dut.cnt_q); end
    req_i = 4'b0010;
    step();
    total++; if (grant_o !== 4'b0010) begin bad++; $display("FAIL lock_idle got=%b want=0010", grant_o); end
    ready_i = 1'b0;
  endtask

  task automatic test_timeout();
    int held = 0;
    int pulses = 0;
    req_i = 4'b0011; ready_i = 1'b0;
    step();
    total++; if (grant_o !== 4'b0001) begin bad++; $display("FAIL tmo_start got=%b want=0001", grant_o); end
    while (grant_o === 4'b0001 && held < 400) begin
      step();
      if (grant_o === 4'b0001) held++;
      if (timeout_o === 1'b1) pulses++;
    end
    total++; if (held !== 255) begin bad++; $display("FAIL tmo_wait got=%0d want=255", held); end
    total++; if (grant_o !== 4'b0000) begin bad++; $display("FAIL tmo_grant got=%b want=0000", grant_o); end
    total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL tmo_pulse got=%b want=1", timeout_o); end
    total++; if (hold_flag_o !== 1'b1) begin bad++; $display("FAIL tmo_hold got=%b want=1", hold_flag_o); end
    total++; if (grant_idx_o !== 2'd0) begin bad++; $display("FAIL tmo_idx got=%0d want=0", grant_idx_o); end
    req_i = 4'b0010;
    step();
    if (timeout_o === 1'b1) pulses++;
    total++; if (pulses !== 1) begin bad++; $display("FAIL tmo_once got=%0d want=1", pulses); end
    total++; if (grant_o !== 4'b0010) begin bad++; $display("FAIL tmo_idle got=%b want=0010", grant_o); end
    total++; if (hold_flag_o !== 1'b0) begin bad++; $display("FAIL tmo_idle_hold got=%b want=0", hold_flag_o); end
    // ready_i arriving on the compare cycle must beat the abort
    req_i = 4'b0011;
    step();
    repeat (255) step();
    total++; if (dut.cnt_q !== 8'd255) begin bad++; $display("FAIL tmo_sat got=%0d want=255", dut.cnt_q); end
    total++; if (grant_o !== 4'b0001) begin bad++; $display("FAIL tmo_edge_grant got=%b want=0001", grant_o); end
    ready_i = 1'b1; req_i = 4'b0010;
    step();
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL tmo_ready_wins got=%b want=0", timeout_o); end
    total++; if (grant_o !== 4'b0010) begin bad++; $display("FAIL tmo_ready_idle got=%b want=0010", grant_o); end
    ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_beat();
    req_i = 4'b0110; ready_i = 1'b0;
    step(); step(); step();
    total++; if (grant_o !== 4'b0100) begin bad++; $display("FAIL rmid_pre got=%b want=0100", grant_o); end
    rst = 1'b1;
    step();
    total++; if (grant_o !== 4'b0010) begin bad++; $display("FAIL rmid_grant got=%b want=0010", grant_o); end
    total++; if (grant_idx_o !== 2'd1) begin bad++; $display("FAIL rmid_idx got=%0d want=1", grant_idx_o); end
    total++; if (hold_flag_o !== 1'b0) begin bad++; $display("FAIL rmid_hold got=%b want=0", hold_flag_o); end
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL rmid_timeout got=%b want=0", timeout_o); end
    total++; if (dut.cnt_q !== 8'd0) begin bad++; $display("FAIL rmid_cnt got=%0d want=0", dut.cnt_q); end
    req_i = 4'b0010;
    rst = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_seq [6];
`ifdef RIB_ARB_RR_EN
    exp_seq = '{2'd3, 2'd0, 2'd2, 2'd3, 2'd0, 2'd2};
`else
    exp_seq = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
    req_i = 4'b1111; ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      total++;
      if (grant_idx_o !== exp_seq[i] || grant_o !== (4'b0001 << exp_seq[i])) begin
        bad++;
        $display("FAIL b2b_beat%0d got idx=%0d grant=%b want idx=%0d", i, grant_idx_o, grant_o, exp_seq[i]);
      end
    end
    req_i = 4'b0010;
    step();
    total++; if (grant_o !== 4'b0010) begin bad++; $display("FAIL b2b_idle got=%b want=0010", grant_o); end
    ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_lock();
    test_timeout();
    test_reset_mid_beat();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
